// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing controller for a digit-serial significand multiplier.
// It latches the operand exponents and the result sign on start. It spends one
// cycle (EXP) clearing the accumulator and capturing the external exponent
// adder's result. It then steps the accumulator through NDIGITS multiplier
// digits (MUL) and holds the result in DONE until the consumer acknowledges.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, start_ready    multiply request / controller idle
//   E1, E2, S1, S2        operand exponents and signs, sampled with start
//   add_E1, add_E2        latched exponents to the external exponent adder
//   add_Er, add_carry,
//   add_underflow         exponent adder result and flags
//   acc_clr, acc_en       accumulator clear / accumulate-shift enable
//   digit_sel             multiplier digit index for the current step
//   done, done_ack        result valid / consumer acknowledge
//   Er_out, Sr            result exponent and sign
//   overflow, underflow   result exponent range flags
module mul_seq_ctrl #(
  parameter int NDIGITS = 7,
  parameter int EMAX    = 191
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       start_ready,
  input  logic [7:0] E1,
  input  logic [7:0] E2,
  input  logic       S1,
  input  logic       S2,
  output logic [7:0] add_E1,
  output logic [7:0] add_E2,
  input  logic [7:0] add_Er,
  input  logic       add_carry,
  input  logic       add_underflow,
  output logic       acc_clr,
  output logic       acc_en,
  output logic [2:0] digit_sel,
  output logic       done,
  input  logic       done_ack,
  output logic [7:0] Er_out,
  output logic       Sr,
  output logic       overflow,
  output logic       underflow
);

  localparam logic [2:0] LAST_DIGIT = 3'(NDIGITS - 1);
  localparam logic [7:0] EMAX_B     = 8'(EMAX);

  typedef enum logic [1:0] {IDLE, EXP, MUL, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       s_lat;   // operand sign product, held until EXP publishes it

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and Moore outputs
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    digit_sel   = 3'd0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start) state_nxt = EXP;
      end
      EXP: begin
        acc_clr   = 1'b1;
        state_nxt = MUL;
      end
      MUL: begin
        acc_en    = 1'b1;
        digit_sel = cnt;
        if (cnt == LAST_DIGIT) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // start is deliberately not looked at here: an ack wins and the next
        // request is only taken once back in IDLE.
        if (done_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches, digit counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      add_E1    <= 8'd0;
      add_E2    <= 8'd0;
      s_lat     <= 1'b0;
      cnt       <= 3'd0;
      Er_out    <= 8'd0;
      Sr        <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (start) begin
            add_E1 <= E1;
            add_E2 <= E2;
            s_lat  <= S1 ^ S2;
          end
        end
        EXP: begin
          cnt <= 3'd0;
          Sr  <= s_lat;
          if (add_underflow) begin
            underflow <= 1'b1;
            overflow  <= 1'b0;
            Er_out    <= 8'd0;
          end else begin
            underflow <= 1'b0;
            overflow  <= add_carry | (add_Er > EMAX_B);
            Er_out    <= add_Er;
          end
        end
        MUL: begin
          // Wraps back to 0 on the last digit, ready for the next op.
          cnt <= (cnt == LAST_DIGIT) ? 3'd0 : cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
